// File: rtl/light_dimmer_pkg.sv
// Shared definitions for the lamp dimmer: state codes common to the light
// controller and its benches, plus the default parameter values.
package light_dimmer_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_FADE_UP   = 3'd1,
    ST_ON        = 3'd2,
    ST_HOLD      = 3'd3,
    ST_FADE_DOWN = 3'd4
  } light_state_e;

  localparam int DEF_PWM_BITS  = 8;
  localparam int DEF_STEP_DIV  = 16;
  localparam int DEF_STEP_SIZE = 1;
  localparam int DEF_OFF_DELAY = 32;

endpackage

// File: rtl/light_dimmer_if.sv
// Lamp request/drive bundle between the light controller (master) and the dimmer (slave).
interface light_dimmer_if #(
  parameter int PWM_BITS = 8
);
  logic                int_light;
  logic                manual;
  logic                pwm_out;
  logic [PWM_BITS-1:0] duty;
  logic                fading;
  logic                lamp_on;

  modport master (
    output int_light, manual,
    input  pwm_out, duty, fading, lamp_on
  );

  modport slave (
    input  int_light, manual,
    output pwm_out, duty, fading, lamp_on
  );
endinterface

// File: rtl/light_dimmer_pwm_gen.sv
// Free-running PWM counter with a registered compare output; full duty is forced
// high so the lamp sees a constant 1 instead of one dark slot per period.
module light_dimmer_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);
  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] cnt_r;
  logic                pwm_r;

  // counter wraps naturally at MAX; output registered one cycle after duty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {PWM_BITS{1'b0}};
      pwm_r <= 1'b0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      pwm_r <= (duty == MAX) | (cnt_r < duty);
    end
  end

  assign pwm_out = pwm_r;
endmodule

// File: rtl/light_dimmer.sv
// Lamp dimmer: fade-up/fade-down ramps, off-delay hold and manual snap mode,
// driving a PWM generator from the registered duty level.
module light_dimmer
  import light_dimmer_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int STEP_SIZE = DEF_STEP_SIZE,
  parameter int OFF_DELAY = DEF_OFF_DELAY
) (
  input logic           clk,
  input logic           reset,
  light_dimmer_if.slave bus
);
  localparam int PW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int DW = (OFF_DELAY > 1) ? $clog2(OFF_DELAY) : 1;

  localparam logic [PWM_BITS-1:0] MAX        = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP_W     = (PWM_BITS+1)'(STEP_SIZE);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);
  localparam logic [DW-1:0]       DLY_LAST   = DW'(OFF_DELAY - 1);
  localparam logic [DW-1:0]       DLY_ONE    = DW'(1);

  // Sums are formed one bit wider so saturation never sees a wrapped value.
  function automatic logic [PWM_BITS-1:0] sat_up(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] sum_s;
    sum_s = {1'b0, d} + STEP_W;
    if (sum_s > {1'b0, MAX}) sat_up = MAX;
    else                     sat_up = sum_s[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_dn(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] dif_s;
    dif_s = {1'b0, d} - STEP_W;
    if ({1'b0, d} < STEP_W) sat_dn = {PWM_BITS{1'b0}};
    else                    sat_dn = dif_s[PWM_BITS-1:0];
  endfunction

  light_state_e        state_r;
  logic [PWM_BITS-1:0] duty_r;
  logic [PW-1:0]       presc_r;
  logic [DW-1:0]       dly_r;
  logic                tick_s;
  logic [PWM_BITS-1:0] up_s;
  logic [PWM_BITS-1:0] dn_s;
  logic                pwm_s;

  assign tick_s = (presc_r == PRESC_LAST);
  assign up_s   = sat_up(duty_r);
  assign dn_s   = sat_dn(duty_r);

  // dimmer FSM with prescaler, off-delay counter and duty register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_OFF;
      duty_r  <= {PWM_BITS{1'b0}};
      presc_r <= {PW{1'b0}};
      dly_r   <= {DW{1'b0}};
    end else if (bus.manual) begin
      presc_r <= {PW{1'b0}};
      dly_r   <= {DW{1'b0}};
      if (bus.int_light) begin
        state_r <= ST_ON;
        duty_r  <= MAX;
      end else begin
        state_r <= ST_OFF;
        duty_r  <= {PWM_BITS{1'b0}};
      end
    end else begin
      case (state_r)
        ST_OFF: begin
          duty_r <= {PWM_BITS{1'b0}};
          if (bus.int_light) begin
            state_r <= ST_FADE_UP;
            presc_r <= {PW{1'b0}};
          end
        end
        ST_FADE_UP: begin
          if (!bus.int_light) begin
            state_r <= ST_FADE_DOWN;
            presc_r <= {PW{1'b0}};
          end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
            duty_r  <= up_s;
            if (up_s == MAX) state_r <= ST_ON;
          end else begin
            presc_r <= presc_r + PRESC_ONE;
          end
        end
        ST_ON: begin
          duty_r <= MAX;
          if (!bus.int_light) begin
            state_r <= ST_HOLD;
            dly_r   <= {DW{1'b0}};
          end
        end
        // short drops of int_light are absorbed here at full brightness
        ST_HOLD: begin
          duty_r <= MAX;
          if (bus.int_light) begin
            state_r <= ST_ON;
          end else if (dly_r == DLY_LAST) begin
            state_r <= ST_FADE_DOWN;
            presc_r <= {PW{1'b0}};
          end else begin
            dly_r <= dly_r + DLY_ONE;
          end
        end
        ST_FADE_DOWN: begin
          if (bus.int_light) begin
            state_r <= ST_FADE_UP;
            presc_r <= {PW{1'b0}};
          end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
            duty_r  <= dn_s;
            if (dn_s == {PWM_BITS{1'b0}}) state_r <= ST_OFF;
          end else begin
            presc_r <= presc_r + PRESC_ONE;
          end
        end
        default: begin
          state_r <= ST_OFF;
          duty_r  <= {PWM_BITS{1'b0}};
          presc_r <= {PW{1'b0}};
          dly_r   <= {DW{1'b0}};
        end
      endcase
    end
  end

  light_dimmer_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .duty   (duty_r),
    .pwm_out(pwm_s)
  );

  assign bus.pwm_out = pwm_s;
  assign bus.duty    = duty_r;
  assign bus.fading  = (state_r == ST_FADE_UP) || (state_r == ST_FADE_DOWN);
  assign bus.lamp_on = (duty_r != {PWM_BITS{1'b0}});
endmodule

// File: tb/tb_light_dimmer.sv
// Directed bench for light_dimmer (MAX=15, STEP_DIV=2, STEP_SIZE=1, OFF_DELAY=4)
// with a behavioural lamp model checked every cycle plus literal checkpoints.
module tb_light_dimmer;
  localparam int MAXV = 15;
  localparam int SD   = 2;
  localparam int SS   = 1;
  localparam int OD   = 4;

  localparam int M_DARK   = 0;
  localparam int M_RISE   = 1;
  localparam int M_LIT    = 2;
  localparam int M_LINGER = 3;
  localparam int M_SINK   = 4;

  typedef struct {
    int mode;
    int duty;
    int wait_c;
    int lingered;
    int cyc;
    bit pwm;
  } model_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  model_t mdl;

  light_dimmer_if #(.PWM_BITS(4)) bus ();

  light_dimmer #(
    .PWM_BITS (4),
    .STEP_DIV (SD),
    .STEP_SIZE(SS),
    .OFF_DELAY(OD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t r;
    r.mode = M_DARK; r.duty = 0; r.wait_c = 0; r.lingered = 0; r.cyc = 0; r.pwm = 1'b0;
    return r;
  endfunction

  // One clock of lamp behaviour; fade steps use a countdown of cycles left to the next step.
  function automatic model_t advance(model_t m, logic il, logic man);
    model_t n;
    n = m;
    n.cyc = m.cyc + 1;
    n.pwm = (m.duty == MAXV) || ((m.cyc % 16) < m.duty);
    if (man) begin
      n.mode = il ? M_LIT : M_DARK;
      n.duty = il ? MAXV : 0;
      return n;
    end
    case (m.mode)
      M_DARK: if (il) begin n.mode = M_RISE; n.wait_c = SD; end
      M_RISE: begin
        if (!il) begin
          n.mode = M_SINK; n.wait_c = SD;
        end else begin
          n.wait_c = m.wait_c - 1;
          if (n.wait_c == 0) begin
            n.duty = (m.duty + SS > MAXV) ? MAXV : m.duty + SS;
            n.wait_c = SD;
            if (n.duty == MAXV) n.mode = M_LIT;
          end
        end
      end
      M_LIT: if (!il) begin n.mode = M_LINGER; n.lingered = 0; end
      M_LINGER: begin
        if (il) begin
          n.mode = M_LIT;
        end else begin
          n.lingered = m.lingered + 1;
          if (n.lingered == OD) begin n.mode = M_SINK; n.wait_c = SD; end
        end
      end
      M_SINK: begin
        if (il) begin
          n.mode = M_RISE; n.wait_c = SD;
        end else begin
          n.wait_c = m.wait_c - 1;
          if (n.wait_c == 0) begin
            n.duty = (m.duty - SS < 0) ? 0 : m.duty - SS;
            n.wait_c = SD;
            if (n.duty == 0) n.mode = M_DARK;
          end
        end
      end
      default: n.mode = M_DARK;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) mdl <= model_reset();
    else       mdl <= advance(mdl, bus.int_light, bus.manual);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("duty", int'(bus.duty), mdl.duty);
    chk("fading", int'(bus.fading), int'((mdl.mode == M_RISE) || (mdl.mode == M_SINK)));
    chk("lamp_on", int'(bus.lamp_on), int'(mdl.duty != 0));
    chk("pwm_out", int'(bus.pwm_out), int'(mdl.pwm));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_model();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.int_light = 1'b0;
    bus.manual = 1'b0;
    cycles(3);
    chk("reset_duty", int'(bus.duty), 0);
    chk("reset_pwm", int'(bus.pwm_out), 0);
    reset = 1'b0;
    cycles(2);

    // T1 fade up from OFF
    bus.int_light = 1'b1;
    cycles(1);
    chk("t1_fading_start", int'(bus.fading), 1);
    cycles(30);
    chk("t1_duty_full", int'(bus.duty), 15);
    chk("t1_fading_end", int'(bus.fading), 0);
    cycles(16);
    chk("t1_pwm_const1", int'(bus.pwm_out), 1);

    // T2 short drop absorbed by the hold
    bus.int_light = 1'b0;
    cycles(3);
    bus.int_light = 1'b1;
    cycles(3);
    chk("t2_duty", int'(bus.duty), 15);
    chk("t2_fading", int'(bus.fading), 0);

    // T3 off-delay expires, full fade down
    bus.int_light = 1'b0;
    cycles(4);
    chk("t3_still_held", int'(bus.fading), 0);
    cycles(1);
    chk("t3_fade_down", int'(bus.fading), 1);
    cycles(30);
    chk("t3_duty_zero", int'(bus.duty), 0);
    chk("t3_lamp_off", int'(bus.lamp_on), 0);
    cycles(20);
    chk("t3_pwm_const0", int'(bus.pwm_out), 0);

    // T4 reversal mid fade-up
    bus.int_light = 1'b1;
    cycles(15);
    chk("t4_duty7", int'(bus.duty), 7);
    bus.int_light = 1'b0;
    cycles(3);
    chk("t4_duty6", int'(bus.duty), 6);
    bus.int_light = 1'b1;
    cycles(3);
    chk("t4_duty7_again", int'(bus.duty), 7);
    cycles(20);

    // T5 manual snap on/off
    bus.manual = 1'b1;
    bus.int_light = 1'b0;
    cycles(1);
    chk("t5_off_snap", int'(bus.duty), 0);
    bus.int_light = 1'b1;
    cycles(1);
    chk("t5_on_snap", int'(bus.duty), 15);
    chk("t5_no_fade", int'(bus.fading), 0);
    bus.int_light = 1'b0;
    cycles(1);
    chk("t5_off_nodelay", int'(bus.duty), 0);
    bus.manual = 1'b0;
    cycles(3);

    // T6 async reset mid fade-up
    bus.int_light = 1'b1;
    cycles(19);
    chk("t6_duty9", int'(bus.duty), 9);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_duty", int'(bus.duty), 0);
    chk("t6_async_fading", int'(bus.fading), 0);
    chk("t6_async_lamp", int'(bus.lamp_on), 0);
    chk("t6_async_pwm", int'(bus.pwm_out), 0);
    cycles(2);
    reset = 1'b0;
    cycles(3);
    chk("t6_restart_duty", int'(bus.duty), 1);
    chk("t6_restart_fading", int'(bus.fading), 1);
    cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
